// File: rtl/divider_8by4_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first,
// with a start/busy/done handshake. The done pulse trails the DONE state by one register.
module divider_8by4_seq #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam int REM_W = DIVISOR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic                  dbz_q, dbz_d;
    logic                  done_q;

    logic [REM_W-1:0]      shifted;
    logic [REM_W:0]        trial;

    // Shift the next dividend bit into the partial remainder; the extra top bit of
    // trial is the borrow that tells us whether the divisor fits.
    always_comb begin
        shifted = {rem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
        trial   = {1'b0, shifted} - {2'b00, dvs_q};
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    rem_d = '0;
                    if (divisor == '0) begin
                        quo_d   = '1;
                        dbz_d   = 1'b1;
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        quo_d   = '0;
                        dbz_d   = 1'b0;
                        count_d = CNT_W'(DIVIDEND_W);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
                if (!trial[REM_W]) begin
                    rem_d = REM_W'(trial);
                    quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
                end
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= (state_q == DONE);
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = DIVISOR_W'(rem_q);
    assign div_by_zero = dbz_q;

endmodule
